// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares a single-port synchronous data RAM (one-cycle read latency)
//   between the pipeline MEM-stage port and a debug/loader port.
//   Generates the CPU stall, returns read data with a valid strobe, and
//   runs a halt handshake that drains the CPU before debug owns the RAM.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   cpu_req/we/addr/wdata            CPU access request (held until granted)
//   cpu_stall                        CPU request pending and not granted
//   cpu_rdata/cpu_rvalid             CPU load return (cycle after grant)
//   dbg_req/we/addr/wdata            debug access request
//   dbg_gnt                          debug request accepted this cycle
//   dbg_rdata/dbg_rvalid             debug load return (cycle after grant)
//   dbg_halt / dbg_halted            halt request level / CPU excluded
//   ram_addr/ram_data/ram_wren       RAM drive
//   ram_q                            RAM read data
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    input  logic              dbg_halt,
    output logic              dbg_halted,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     r_state, w_state_nxt;
    owner_t     r_rd_owner, w_owner_nxt;
    logic [3:0] r_starve;
    logic       w_dbg_grant, w_cpu_grant;

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        w_dbg_grant = rst_n && dbg_req &&
                      (r_state != ST_RUN || r_starve == LIMIT || !cpu_req);
        w_cpu_grant = rst_n && cpu_req && r_state == ST_RUN && !w_dbg_grant;
    end

    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_wren = 1'b0;
        if (w_dbg_grant) begin
            ram_addr = dbg_addr;
            ram_data = dbg_wdata;
            ram_wren = dbg_we;
        end else if (w_cpu_grant) begin
            ram_addr = cpu_addr;
            ram_data = cpu_wdata;
            ram_wren = cpu_we;
        end
    end

    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_cpu_grant && !cpu_we)      w_owner_nxt = OWN_CPU;
        else if (w_dbg_grant && !dbg_we) w_owner_nxt = OWN_DBG;
    end

    // CPU is never granted outside RUN, so any CPU load still in flight on
    // entering DRAIN returns during the first DRAIN cycle; HALTED follows
    // as soon as no CPU load will be outstanding in the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:    if (dbg_halt) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!dbg_halt)                  w_state_nxt = ST_RUN;
                       else if (w_owner_nxt != OWN_CPU) w_state_nxt = ST_HALTED;
            ST_HALTED: if (!dbg_halt) w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_rd_owner <= OWN_NONE;
            r_starve   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_owner <= w_owner_nxt;
            if (dbg_req && !w_dbg_grant)
                r_starve <= (r_starve == LIMIT) ? r_starve : r_starve + 4'd1;
            else
                r_starve <= '0;
        end
    end

    assign cpu_stall  = cpu_req && !w_cpu_grant;
    assign dbg_gnt    = w_dbg_grant;
    assign cpu_rdata  = ram_q;
    assign dbg_rdata  = ram_q;
    assign cpu_rvalid = (r_rd_owner == OWN_CPU);
    assign dbg_rvalid = (r_rd_owner == OWN_DBG);
    assign dbg_halted = (r_state == ST_HALTED);

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/100ps
module tb_dmem_arbiter;

    localparam int LIM = 4;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [7:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_halt = 1'b0;
    logic        dbg_halted;
    logic [7:0]  ram_addr;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
        .dbg_halt(dbg_halt), .dbg_halted(dbg_halted),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // Write-first synchronous RAM seen by the arbiter.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (ram_wren) ram[ram_addr] <= ram_data;
        ram_q <= ram_wren ? ram_data : ram[ram_addr];
    end

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: arbitration rules, expected memory image, pending return.
    int          m_mode, m_starve, m_ret;   // m_ret: 0 none, 1 cpu, 2 dbg
    logic [31:0] m_ret_data;
    bit          m_ret_known;
    logic [31:0] ref_mem [256];
    bit          ref_wr [256];
    bit          e_cpu, e_dbg, obs_dbg;

    task automatic model_reset();
        m_mode = M_RUN; m_starve = 0; m_ret = 0;
        e_cpu = 1'b0; e_dbg = 1'b0;
    endtask

    // One clock cycle: compare at negedge against the rules, then advance model.
    task automatic step();
        bit ed, ec;
        bit exp_wren;
        @(negedge clk);
        ed = dbg_req && (m_mode != M_RUN || m_starve == LIM || !cpu_req);
        ec = cpu_req && m_mode == M_RUN && !ed;
        exp_wren = (ec && cpu_we) || (ed && dbg_we);
        chk("cpu_stall", cpu_stall, cpu_req && !ec);
        chk("dbg_gnt", dbg_gnt, ed);
        chk("ram_wren", ram_wren, exp_wren);
        chk("ram_addr", ram_addr, ed ? dbg_addr : (ec ? cpu_addr : 8'h0));
        if (exp_wren) chk("ram_data", ram_data, ed ? dbg_wdata : cpu_wdata);
        chk("cpu_rvalid", cpu_rvalid, m_ret == 1);
        chk("dbg_rvalid", dbg_rvalid, m_ret == 2);
        if (m_ret == 1 && m_ret_known) chk("cpu_rdata", cpu_rdata, m_ret_data);
        if (m_ret == 2 && m_ret_known) chk("dbg_rdata", dbg_rdata, m_ret_data);
        chk("dbg_halted", dbg_halted, m_mode == M_HALTED);
        obs_dbg = dbg_gnt; e_cpu = ec; e_dbg = ed;
        m_ret = 0;
        if (ec) begin
            if (cpu_we) begin ref_mem[cpu_addr] = cpu_wdata; ref_wr[cpu_addr] = 1'b1; end
            else begin m_ret = 1; m_ret_data = ref_mem[cpu_addr]; m_ret_known = ref_wr[cpu_addr]; end
        end
        if (ed) begin
            if (dbg_we) begin ref_mem[dbg_addr] = dbg_wdata; ref_wr[dbg_addr] = 1'b1; end
            else begin m_ret = 2; m_ret_data = ref_mem[dbg_addr]; m_ret_known = ref_wr[dbg_addr]; end
        end
        if (dbg_req && !ed) m_starve = (m_starve < LIM) ? m_starve + 1 : m_starve;
        else m_starve = 0;
        case (m_mode)
            M_RUN:    if (dbg_halt) m_mode = M_DRAIN;
            M_DRAIN:  m_mode = dbg_halt ? M_HALTED : M_RUN;  // no CPU load can be issued here
            default:  if (!dbg_halt) m_mode = M_RUN;
        endcase
        @(posedge clk); #1;
    endtask

    task automatic set_cpu(input bit req, input bit we, input int a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = 8'(a); cpu_wdata = d;
    endtask

    task automatic set_dbg(input bit req, input bit we, input int a, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = 8'(a); dbg_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; ref_wr[i] = 1'b0; end
        model_reset();

        // Reset state: everything quiet, CPU stalled if requesting.
        cpu_req = 1'b1;
        #3;
        chk("rst_stall", cpu_stall, 1'b1);
        chk("rst_wren", ram_wren, 1'b0);
        chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk("rst_dbg_rvalid", dbg_rvalid, 1'b0);
        chk("rst_halted", dbg_halted, 1'b0);
        chk("rst_dbg_gnt", dbg_gnt, 1'b0);
        cpu_req = 1'b0;
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // Store then load back-to-back.
        set_cpu(1, 1, 'h10, 32'hDEADBEEF); step();
        set_cpu(1, 0, 'h10, 32'h0);        step();
        chk("st_ld_rvalid", cpu_rvalid, 1'b1);
        chk("st_ld_rdata", cpu_rdata, 32'hDEADBEEF);
        set_cpu(0, 0, 0, 0); step();

        // Both ports held: debug wins every fifth cycle.
        set_cpu(1, 1, 'h20, 32'h1111);
        set_dbg(1, 1, 'h21, 32'h2222);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("starve_pat", obs_dbg, (i % 5) == 4);
        end
        set_cpu(0, 0, 0, 0); set_dbg(0, 0, 0, 0); step();

        // Halt raised in the same cycle as a CPU load grant.
        set_cpu(1, 0, 'h10, 0); dbg_halt = 1'b1; step();
        chk("drain_rvalid", cpu_rvalid, 1'b1);
        chk("drain_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("drain_halted", dbg_halted, 1'b0);
        set_cpu(1, 1, 'h30, 32'h3333); step();
        chk("halted_rise", dbg_halted, 1'b1);
        chk("halted_stall", cpu_stall, 1'b1);

        // Debug owns the RAM while halted.
        for (int i = 0; i < 4; i++) begin set_dbg(1, 1, i, 32'(i + 1)); step(); end
        for (int i = 0; i < 4; i++) begin
            set_dbg(1, 0, i, 0); step();
            chk("halt_dbg_rvalid", dbg_rvalid, 1'b1);
            chk("halt_dbg_rdata", dbg_rdata, 32'(i + 1));
            chk("halt_cpu_rvalid", cpu_rvalid, 1'b0);
        end
        set_dbg(0, 0, 0, 0); set_cpu(0, 0, 0, 0); dbg_halt = 1'b0; step();
        chk("resume_run", dbg_halted, 1'b0);

        // Debug alone is granted every cycle.
        for (int i = 0; i < 4; i++) begin
            set_dbg(1, i[0], 'h40 + i, 32'hA0 + 32'(i)); step();
            chk("dbg_only_gnt", obs_dbg, 1'b1);
        end

        // Reset pulse in the return cycle of a debug load.
        set_cpu(1, 1, 'h50, 32'h5555); set_dbg(1, 0, 2, 0);
        begin
            int guard = 0;
            obs_dbg = 1'b0;
            while (!obs_dbg && guard < 10) begin step(); guard++; end
            chk("rst_pulse_dbg_grant", obs_dbg, 1'b1);
        end
        rst_n = 1'b0;
        #1;
        chk("rstp_dbg_rvalid", dbg_rvalid, 1'b0);
        chk("rstp_stall", cpu_stall, 1'b1);
        chk("rstp_wren", ram_wren, 1'b0);
        model_reset();
        #2.5 rst_n = 1'b1;
        step();
        chk("rstp_cpu_first", obs_dbg, 1'b0);
        chk("rstp_no_rvalid", dbg_rvalid, 1'b0);
        set_cpu(0, 0, 0, 0); set_dbg(0, 0, 0, 0); step();

        // Randomized traffic with halts.
        for (int n = 0; n < 500; n++) begin
            if (!cpu_req || e_cpu)
                set_cpu($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
            if (!dbg_req || e_dbg)
                set_dbg($urandom_range(0, 99) < 40, $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
            if ($urandom_range(0, 19) == 0) dbg_halt = !dbg_halt;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
